sobel_gradient: RTL and testbench

Streaming 3x3 Sobel gradient stage placed directly upstream of the magnitude/sqrt stage. It takes one 3-pixel column per accepted beat from the line buffer and keeps a sliding 3-column window. For each full window it computes signed Gx/Gy and the saturated sum of squares, then hands that sum to the sqrt stage over a valid/ready handshake. Backpressure stalls the whole pipeline, so no column or result is lost.

---
 rtl/sobel_pkg.sv | 41 ++++
 rtl/sobel_kernel.sv | 37 +++
 rtl/sobel_gradient.sv | 130 +++++++++++++
 tb/tb_sobel_gradient.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and arithmetic helpers for the Sobel gradient stage.
// Widths are sized so the kernel can never overflow and only the sum of squares saturates.
package sobel_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned GRAD_W  = 11;
  localparam int unsigned SUMSQ_W = 20;

  localparam logic [SUMSQ_W-1:0] SUMSQ_MAX = 20'hFFFFF;

  typedef logic [PIX_W-1:0]         pixel_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [SUMSQ_W-1:0]       sumsq_t;

  // Wide enough for the unclamped Gx^2 + Gy^2 (max 2080800).
  typedef logic [2*GRAD_W:0] sq_sum_t;

  typedef struct packed {
    pixel_t top;
    pixel_t mid;
    pixel_t bot;
  } column_t;

  function automatic grad_t to_grad(pixel_t p);
    return grad_t'({{(GRAD_W - PIX_W){1'b0}}, p});
  endfunction

  function automatic sumsq_t sat_sumsq(grad_t gx, grad_t gy);
    logic signed [2*GRAD_W-1:0] gx_sq;
    logic signed [2*GRAD_W-1:0] gy_sq;
    sq_sum_t                    sum;
    gx_sq = gx * gx;
    gy_sq = gy * gy;
    sum   = {1'b0, gx_sq} + {1'b0, gy_sq};
    if (sum > sq_sum_t'(SUMSQ_MAX)) begin
      return SUMSQ_MAX;
    end
    return sum[SUMSQ_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel kernel: p<row><col>, column 0 oldest, produces signed Gx/Gy.
// Kept free of any state so it can be reused by the direction logic.
module sobel_kernel
  import sobel_pkg::*;
(
  input  logic [PIX_W-1:0]         p00,
  input  logic [PIX_W-1:0]         p01,
  input  logic [PIX_W-1:0]         p02,
  input  logic [PIX_W-1:0]         p10,
  input  logic [PIX_W-1:0]         p11,
  input  logic [PIX_W-1:0]         p12,
  input  logic [PIX_W-1:0]         p20,
  input  logic [PIX_W-1:0]         p21,
  input  logic [PIX_W-1:0]         p22,
  output logic signed [GRAD_W-1:0] gx,
  output logic signed [GRAD_W-1:0] gy
);

  grad_t e00, e01, e02, e10, e12, e20, e21, e22;

  assign e00 = to_grad(p00);
  assign e01 = to_grad(p01);
  assign e02 = to_grad(p02);
  assign e10 = to_grad(p10);
  assign e12 = to_grad(p12);
  assign e20 = to_grad(p20);
  assign e21 = to_grad(p21);
  assign e22 = to_grad(p22);

  // Centre pixel carries zero weight in both kernels.
  logic unused_centre;
  assign unused_centre = ^p11;

  assign gx = (e02 + (e12 <<< 1) + e22) - (e00 + (e10 <<< 1) + e20);
  assign gy = (e00 + (e01 <<< 1) + e02) - (e20 + (e21 <<< 1) + e22);

endmodule

// File: rtl/sobel_gradient.sv
// Streaming Sobel gradient: sliding 3-column window, two-stage pipeline (kernel, then
// saturated sum of squares) with a single stall that freezes every stage.
module sobel_gradient
  import sobel_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      col_valid,
  output logic                      col_ready,
  input  logic [PIX_W-1:0]          col_top,
  input  logic [PIX_W-1:0]          col_mid,
  input  logic [PIX_W-1:0]          col_bot,
  input  logic                      row_start,
  input  logic                      col_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SUMSQ_W-1:0]        out_data,
  output logic signed [GRAD_W-1:0]  out_gx,
  output logic signed [GRAD_W-1:0]  out_gy,
  output logic                      out_last
);

  localparam logic [1:0] CntFull = 2'd3;

  column_t col_in;
  column_t col_old_q;  // window column 0 once the incoming column shifts in
  column_t col_new_q;  // window column 1 once the incoming column shifts in

  logic [1:0] cnt_q, cnt_d;
  logic       stall;
  logic       accept;
  logic       s1_load;

  grad_t  k_gx, k_gy;
  grad_t  s1_gx_q, s1_gy_q;
  logic   s1_valid_q, s1_last_q;

  logic   out_valid_q, out_last_q;
  sumsq_t out_data_q, sumsq;
  grad_t  out_gx_q, out_gy_q;

  assign col_in.top = col_top;
  assign col_in.mid = col_mid;
  assign col_in.bot = col_bot;

  assign stall     = out_valid_q & ~out_ready;
  assign col_ready = reset_n & ~stall;
  assign accept    = col_valid & col_ready;

  // row_start makes the carrying column the first of a fresh window.
  always_comb begin
    cnt_d = cnt_q;
    if (row_start) begin
      cnt_d = 2'd1;
    end else if (cnt_q != CntFull) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  assign s1_load = accept & (cnt_d == CntFull);

  sobel_kernel u_kernel (
    .p00 (col_old_q.top),
    .p01 (col_new_q.top),
    .p02 (col_in.top),
    .p10 (col_old_q.mid),
    .p11 (col_new_q.mid),
    .p12 (col_in.mid),
    .p20 (col_old_q.bot),
    .p21 (col_new_q.bot),
    .p22 (col_in.bot),
    .gx  (k_gx),
    .gy  (k_gy)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_old_q <= '0;
      col_new_q <= '0;
      cnt_q     <= '0;
    end else if (accept) begin
      col_old_q <= col_new_q;
      col_new_q <= col_in;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_gx_q    <= '0;
      s1_gy_q    <= '0;
      s1_last_q  <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= s1_load;
      if (s1_load) begin
        s1_gx_q   <= k_gx;
        s1_gy_q   <= k_gy;
        s1_last_q <= col_last;
      end
    end
  end

  assign sumsq = sat_sumsq(s1_gx_q, s1_gy_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_gx_q    <= '0;
      out_gy_q    <= '0;
      out_last_q  <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= sumsq;
        out_gx_q   <= s1_gx_q;
        out_gy_q   <= s1_gy_q;
        out_last_q <= s1_last_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_gx    = out_gx_q;
  assign out_gy    = out_gy_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_sobel_gradient.sv
// Bench for sobel_gradient: directed scenarios plus randomized rows with random backpressure,
// checked against a column-queue Sobel model.
module tb_sobel_gradient;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              col_valid = 1'b0;
  logic              col_ready;
  logic [7:0]        col_top = '0;
  logic [7:0]        col_mid = '0;
  logic [7:0]        col_bot = '0;
  logic              row_start = 1'b0;
  logic              col_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [19:0]       out_data;
  logic signed [10:0] out_gx;
  logic signed [10:0] out_gy;
  logic              out_last;

  sobel_gradient dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .col_top   (col_top),
    .col_mid   (col_mid),
    .col_bot   (col_bot),
    .row_start (row_start),
    .col_last  (col_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_gx    (out_gx),
    .out_gy    (out_gy),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int gx;
    int gy;
    bit last;
  } res_t;

  res_t exp_q[$];
  res_t rx_q[$];
  int   mt[$], mm[$], mb[$];  // current row's last three columns, oldest first
  int   errors = 0;
  int   checks = 0;
  bit   rand_ready = 1'b0;

  function automatic void model_clear();
    mt.delete(); mm.delete(); mb.delete();
    exp_q.delete();
  endfunction

  function automatic void model_accept(int t, int m, int b, bit rs, bit cl);
    res_t r;
    int   sq;
    if (rs) begin
      mt.delete(); mm.delete(); mb.delete();
    end
    mt.push_back(t); mm.push_back(m); mb.push_back(b);
    if (mt.size() > 3) begin
      void'(mt.pop_front()); void'(mm.pop_front()); void'(mb.pop_front());
    end
    if (mt.size() == 3) begin
      r.gx   = (mt[2] - mt[0]) + 2 * (mm[2] - mm[0]) + (mb[2] - mb[0]);
      r.gy   = (mt[0] + 2 * mt[1] + mt[2]) - (mb[0] + 2 * mb[1] + mb[2]);
      sq     = r.gx * r.gx + r.gy * r.gy;
      r.data = (sq > 1048575) ? 1048575 : sq;
      r.last = cl;
      exp_q.push_back(r);
    end
  endfunction

  // Negedge sees exactly what the next posedge will sample.
  always @(negedge clk) begin : monitor
    res_t got;
    res_t want;
    if (reset_n) begin
      if (out_valid && out_ready) begin
        got.data = int'(out_data);
        got.gx   = int'(out_gx);
        got.gy   = int'(out_gy);
        got.last = out_last;
        rx_q.push_back(got);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got data=%0d gx=%0d gy=%0d, required no result",
                   got.data, got.gx, got.gy);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL sb_result: got data=%0d gx=%0d gy=%0d last=%0b, required data=%0d gx=%0d gy=%0d last=%0b",
                     got.data, got.gx, got.gy, got.last, want.data, want.gx, want.gy, want.last);
          end
        end
      end
      if (col_valid && col_ready) begin
        model_accept(int'(col_top), int'(col_mid), int'(col_bot), row_start, col_last);
      end
    end
  end

  task automatic send(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b,
                      input bit rs, input bit cl);
    int guard;
    bit acc;
    col_valid = 1'b1;
    col_top = t; col_mid = m; col_bot = b;
    row_start = rs; col_last = cl;
    guard = 0;
    do begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = col_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: got col_ready=0 for 200 cycles, required acceptance");
    end
    col_valid = 1'b0; row_start = 1'b0; col_last = 1'b0;
  endtask

  task automatic idle(input int n);
    col_valid = 1'b0;
    repeat (n) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    idle(6);
  endtask

  function automatic logic [7:0] rand_pix();
    case ($urandom_range(0, 5))
      0:       return 8'd0;
      1:       return 8'd255;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++;
    if (col_ready !== 1'b0) begin errors++; $display("FAIL reset_col_ready: got %b, required 0", col_ready); end
    checks++;
    if (out_data !== 20'd0 || out_gx !== 11'sd0 || out_gy !== 11'sd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%0d gx=%0d gy=%0d last=%b, required all 0",
               out_data, out_gx, out_gy, out_last);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (col_ready !== 1'b1) begin errors++; $display("FAIL release_col_ready: got %b, required 1", col_ready); end
    model_clear();
  endtask

  task automatic test_uniform_row();
    rx_q.delete();
    for (int i = 0; i < 5; i++) send(8'd100, 8'd100, 8'd100, i == 0, i == 4);
    drain();
    checks++;
    if (rx_q.size() != 3) begin errors++; $display("FAIL uniform_count: got %0d, required 3", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 3; i++) begin
      checks++;
      if (rx_q[i].data != 0 || rx_q[i].gx != 0 || rx_q[i].gy != 0 || rx_q[i].last != (i == 2)) begin
        errors++;
        $display("FAIL uniform_res%0d: got data=%0d gx=%0d gy=%0d last=%0b, required 0 0 0 last=%0b",
                 i, rx_q[i].data, rx_q[i].gx, rx_q[i].gy, rx_q[i].last, i == 2);
      end
    end
  endtask

  task automatic test_vertical();
    rx_q.delete();
    for (int i = 0; i < 3; i++) send(8'd255, 8'd0, 8'd0, i == 0, i == 2);
    drain();
    checks++;
    if (rx_q.size() != 1) begin
      errors++; $display("FAIL vertical_count: got %0d, required 1", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0].gx != 0 || rx_q[0].gy != 1020 || rx_q[0].data != 1040400) begin
        errors++;
        $display("FAIL vertical_res: got gx=%0d gy=%0d data=%0d, required 0 1020 1040400",
                 rx_q[0].gx, rx_q[0].gy, rx_q[0].data);
      end
    end
  endtask

  task automatic test_horizontal_sat();
    rx_q.delete();
    send(8'd255, 8'd255, 8'd255, 1'b1, 1'b0);
    send(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    send(8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    send(8'd255, 8'd0, 8'd0, 1'b1, 1'b0);
    send(8'd255, 8'd0, 8'd0, 1'b0, 1'b0);
    send(8'd255, 8'd255, 8'd255, 1'b0, 1'b1);
    drain();
    checks++;
    if (rx_q.size() != 2) begin
      errors++; $display("FAIL horiz_count: got %0d, required 2", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0].gx != -1020 || rx_q[0].gy != 0 || rx_q[0].data != 1040400) begin
        errors++;
        $display("FAIL horiz_res: got gx=%0d gy=%0d data=%0d, required -1020 0 1040400",
                 rx_q[0].gx, rx_q[0].gy, rx_q[0].data);
      end
      checks++;
      if (rx_q[1].gx != 765 || rx_q[1].gy != 765 || rx_q[1].data != 1048575) begin
        errors++;
        $display("FAIL sat_res: got gx=%0d gy=%0d data=%0d, required 765 765 1048575",
                 rx_q[1].gx, rx_q[1].gy, rx_q[1].data);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] t6, m6, b6;
    logic [19:0] held_data;
    logic signed [10:0] held_gx;
    rx_q.delete();
    for (int i = 0; i < 5; i++) send(rand_pix(), rand_pix(), rand_pix(), i == 0, 1'b0);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_pre_valid: got %b, required 1", out_valid); end
    held_data = out_data;
    held_gx = out_gx;
    t6 = rand_pix(); m6 = rand_pix(); b6 = rand_pix();
    col_top = t6; col_mid = m6; col_bot = b6; col_valid = 1'b1;
    out_ready = 1'b0;
    #1;
    checks++;
    if (col_ready !== 1'b0) begin errors++; $display("FAIL stall_col_ready: got %b, required 0", col_ready); end
    repeat (4) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== held_data || out_gx !== held_gx || col_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b data=%0d gx=%0d col_ready=%b, required 1 %0d %0d 0",
                 out_valid, out_data, out_gx, col_ready, held_data, held_gx);
      end
    end
    out_ready = 1'b1;
    send(t6, m6, b6, 1'b0, 1'b0);
    for (int i = 6; i < 10; i++) send(rand_pix(), rand_pix(), rand_pix(), 1'b0, i == 9);
    drain();
    checks++;
    if (rx_q.size() != 8) begin errors++; $display("FAIL stall_count: got %0d, required 8", rx_q.size()); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_row_restart();
    rx_q.delete();
    send(rand_pix(), rand_pix(), rand_pix(), 1'b1, 1'b0);
    send(rand_pix(), rand_pix(), rand_pix(), 1'b0, 1'b0);
    send(rand_pix(), rand_pix(), rand_pix(), 1'b1, 1'b0);
    send(rand_pix(), rand_pix(), rand_pix(), 1'b0, 1'b0);
    idle(4);
    checks++;
    if (rx_q.size() != 0) begin errors++; $display("FAIL restart_early: got %0d results, required 0", rx_q.size()); end
    send(rand_pix(), rand_pix(), rand_pix(), 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL restart_lat1: got valid=%b, required 0", out_valid); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL restart_lat2: got valid=%b, required 1", out_valid); end
    drain();
    checks++;
    if (rx_q.size() != 1) begin errors++; $display("FAIL restart_count: got %0d, required 1", rx_q.size()); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_pix(), rand_pix(), rand_pix(), i == 0, 1'b0);
    idle(1);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b, required 1", out_valid); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || col_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got valid=%b col_ready=%b, required 0 0", out_valid, col_ready);
    end
    model_clear();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    rx_q.delete();
    send(rand_pix(), rand_pix(), rand_pix(), 1'b0, 1'b0);
    send(rand_pix(), rand_pix(), rand_pix(), 1'b0, 1'b0);
    idle(3);
    checks++;
    if (rx_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_early: got %0d results valid=%b, required 0 0", rx_q.size(), out_valid);
    end
    send(rand_pix(), rand_pix(), rand_pix(), 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_lat1: got valid=%b, required 0", out_valid); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_lat2: got valid=%b, required 1", out_valid); end
    drain();
    checks++;
    if (rx_q.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d, required 1", rx_q.size()); end
  endtask

  task automatic test_random_rows();
    int len;
    bit rs;
    rx_q.delete();
    rand_ready = 1'b1;
    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        rs = (c == 0) && ($urandom_range(0, 4) != 0);
        send(rand_pix(), rand_pix(), rand_pix(), rs,
             (c == len - 1) || ($urandom_range(0, 9) == 0));
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL random_pending: got %0d, required 0", exp_q.size()); end
    checks++;
    if (rx_q.size() == 0) begin errors++; $display("FAIL random_none: got 0 results, required some"); end
  endtask

  initial begin
    test_reset();
    test_uniform_row();
    test_vertical();
    test_horizontal_sat();
    test_stall();
    test_row_restart();
    test_reset_midstream();
    test_random_rows();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
